// File: rtl/vrf_banked.sv
// rtl/vrf_banked.sv - banked vector register file with round-robin read arbitration
//
// Purpose: element storage split across NumBanks single-ported banks. The bank
// is the element index modulo NumBanks. One write port always wins its bank.
// NumRdPorts read ports arbitrate per bank. Reads that hit the same row of one
// bank share a single access, so every such port is granted together.
// Read data is registered and appears one cycle after the grant.
//
// Ports:
//   clk, nrst              clock, asynchronous active-low reset
//   rd_valid/rd_vreg/rd_elem  per-port read request, register and element index
//   rd_ready               per-port combinational grant
//   rd_rvalid/rd_rdata     per-port read response, one cycle after grant
//   wr_valid/wr_vreg/wr_elem/wr_data/wr_be  write request with byte enables
//   wr_ready               write grant, always high
//   conflict_cnt           saturating count of stalled read-port cycles
module vrf_banked #(
  parameter int NumVRs     = 32,
  parameter int ElemsPerVR = 32,
  parameter int NumBanks   = 4,
  parameter int DataWidth  = 32,
  parameter int NumRdPorts = 2
) (
  input  logic                                          clk,
  input  logic                                          nrst,
  input  logic [NumRdPorts-1:0]                         rd_valid,
  input  logic [NumRdPorts-1:0][$clog2(NumVRs)-1:0]     rd_vreg,
  input  logic [NumRdPorts-1:0][$clog2(ElemsPerVR)-1:0] rd_elem,
  output logic [NumRdPorts-1:0]                         rd_ready,
  output logic [NumRdPorts-1:0]                         rd_rvalid,
  output logic [NumRdPorts-1:0][DataWidth-1:0]          rd_rdata,
  input  logic                                          wr_valid,
  input  logic [$clog2(NumVRs)-1:0]                     wr_vreg,
  input  logic [$clog2(ElemsPerVR)-1:0]                 wr_elem,
  input  logic [DataWidth-1:0]                          wr_data,
  input  logic [DataWidth/8-1:0]                        wr_be,
  output logic                                          wr_ready,
  output logic [15:0]                                   conflict_cnt
);

  localparam int VregW     = $clog2(NumVRs);
  localparam int ElemW     = $clog2(ElemsPerVR);
  localparam int BankW     = $clog2(NumBanks);
  localparam int RowsPerVR = ElemsPerVR / NumBanks;
  localparam int Rows      = NumVRs * RowsPerVR;
  localparam int RowW      = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int PortW     = (NumRdPorts > 1) ? $clog2(NumRdPorts) : 1;
  localparam int NumBytes  = DataWidth / 8;

  // Row inside a bank: register-major, then element / NumBanks.
  function automatic logic [RowW-1:0] row_of(input logic [VregW-1:0] vreg,
                                             input logic [ElemW-1:0] elem);
    return RowW'(vreg) * RowW'(RowsPerVR) + RowW'(elem >> BankW);
  endfunction

  // k-th port in round-robin order, counting from the bank pointer.
  function automatic int port_at(input logic [PortW-1:0] ptr, input int k);
    return (int'(ptr) + k) % NumRdPorts;
  endfunction

  logic [DataWidth-1:0]             mem_q [NumBanks][Rows];
  logic [PortW-1:0]                 ptr_q [NumBanks];
  logic [PortW-1:0]                 ptr_d [NumBanks];
  logic [PortW-1:0]                 win   [NumBanks];
  logic [NumBanks-1:0]              bank_hit;
  logic [NumRdPorts-1:0]            rvalid_q;
  logic [NumRdPorts-1:0][DataWidth-1:0] rdata_q;
  logic [15:0]                      cnt_q;
  logic [15:0]                      cnt_d;
  logic [16:0]                      cnt_sum;

  logic [NumRdPorts-1:0][BankW-1:0] rd_bank;
  logic [NumRdPorts-1:0][RowW-1:0]  rd_row;
  logic [BankW-1:0]                 wr_bank;
  logic [RowW-1:0]                  wr_row;

  always_comb begin
    for (int p = 0; p < NumRdPorts; p++) begin
      rd_bank[p] = rd_elem[p][BankW-1:0];
      rd_row[p]  = row_of(rd_vreg[p], rd_elem[p]);
    end
    wr_bank = wr_elem[BankW-1:0];
    wr_row  = row_of(wr_vreg, wr_elem);
  end

  // Per-bank arbitration. The winner is the first requesting port at or after
  // the pointer. Every other requester on the same row rides along on that
  // single access. A write to the bank blocks all reads and leaves the
  // pointer untouched.
  always_comb begin
    rd_ready = '0;
    bank_hit = '0;
    for (int b = 0; b < NumBanks; b++) begin
      win[b]   = '0;
      ptr_d[b] = ptr_q[b];
    end
    for (int b = 0; b < NumBanks; b++) begin
      if (!(wr_valid && (wr_bank == BankW'(b)))) begin
        for (int k = 0; k < NumRdPorts; k++) begin
          if (!bank_hit[b] && rd_valid[port_at(ptr_q[b], k)] &&
              (rd_bank[port_at(ptr_q[b], k)] == BankW'(b))) begin
            bank_hit[b] = 1'b1;
            win[b]      = PortW'(port_at(ptr_q[b], k));
          end
        end
        if (bank_hit[b]) begin
          for (int p = 0; p < NumRdPorts; p++) begin
            if (rd_valid[p] && (rd_bank[p] == BankW'(b)) &&
                (rd_row[p] == rd_row[win[b]])) begin
              rd_ready[p] = 1'b1;
            end
          end
          ptr_d[b] = (int'(win[b]) == NumRdPorts - 1) ? '0 : win[b] + 1'b1;
        end
      end
    end
  end

  // Stalled ports are added in one step. The 17th bit catches the overflow
  // so the count can clamp at 0xFFFF.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + 17'($countones(rd_valid & ~rd_ready));
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int b = 0; b < NumBanks; b++) begin
        for (int r = 0; r < Rows; r++) begin
          mem_q[b][r] <= '0;
        end
        ptr_q[b] <= '0;
      end
      rvalid_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_valid) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (wr_be[i]) begin
            mem_q[wr_bank][wr_row][8*i +: 8] <= wr_data[8*i +: 8];
          end
        end
      end
      for (int b = 0; b < NumBanks; b++) begin
        ptr_q[b] <= ptr_d[b];
      end
      rvalid_q <= rd_valid & rd_ready;
      for (int p = 0; p < NumRdPorts; p++) begin
        if (rd_valid[p] && rd_ready[p]) begin
          rdata_q[p] <= mem_q[rd_bank[p]][rd_row[p]];
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign rd_rvalid    = rvalid_q;
  assign rd_rdata     = rdata_q;
  assign wr_ready     = 1'b1;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vrf_banked.sv
// tb/tb_vrf_banked.sv - scoreboard testbench for vrf_banked
module tb_vrf_banked;

  logic             clk = 1'b0;
  logic             nrst;
  logic [1:0]       rd_valid;
  logic [1:0][4:0]  rd_vreg;
  logic [1:0][4:0]  rd_elem;
  logic [1:0]       rd_ready;
  logic [1:0]       rd_rvalid;
  logic [1:0][31:0] rd_rdata;
  logic             wr_valid;
  logic [4:0]       wr_vreg;
  logic [4:0]       wr_elem;
  logic [31:0]      wr_data;
  logic [3:0]       wr_be;
  logic             wr_ready;
  logic [15:0]      conflict_cnt;

  vrf_banked dut (
    .clk          (clk),
    .nrst         (nrst),
    .rd_valid     (rd_valid),
    .rd_vreg      (rd_vreg),
    .rd_elem      (rd_elem),
    .rd_ready     (rd_ready),
    .rd_rvalid    (rd_rvalid),
    .rd_rdata     (rd_rdata),
    .wr_valid     (wr_valid),
    .wr_vreg      (wr_vreg),
    .wr_elem      (wr_elem),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .wr_ready     (wr_ready),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] data;
  } sb_t;

  sb_t         sb [$];
  logic [31:0] model [32][32];
  logic [31:0] last_data [2];
  logic [15:0] cnt_model;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat_add(input logic [15:0] a, input int n);
    int s;
    s = int'(a) + n;
    return (s > 32'hFFFF) ? 16'hFFFF : 16'(s);
  endfunction

  task automatic model_clear();
    for (int v = 0; v < 32; v++)
      for (int e = 0; e < 32; e++)
        model[v][e] = '0;
    last_data[0] = '0;
    last_data[1] = '0;
    cnt_model    = '0;
    sb.delete();
  endtask

  task automatic idle();
    rd_valid = '0;
    rd_vreg  = '0;
    rd_elem  = '0;
    wr_valid = 1'b0;
    wr_vreg  = '0;
    wr_elem  = '0;
    wr_data  = '0;
    wr_be    = '0;
  endtask

  task automatic drive_rd(input int p, input int vreg, input int elem);
    rd_valid[p] = 1'b1;
    rd_vreg[p]  = 5'(vreg);
    rd_elem[p]  = 5'(elem);
  endtask

  task automatic drive_wr(input int vreg, input int elem, input logic [31:0] data,
                          input logic [3:0] be);
    wr_valid = 1'b1;
    wr_vreg  = 5'(vreg);
    wr_elem  = 5'(elem);
    wr_data  = data;
    wr_be    = be;
  endtask

  // Inputs are already driven. Check the grants, push the expected data for
  // the granted ports, clock once, then pop and compare the responses.
  task automatic step(input logic [1:0] exp_rdy);
    logic [1:0] exp_rv;
    sb_t        e;
    #1;
    check_eq("rd_ready", 32'(rd_ready), 32'(exp_rdy));
    exp_rv = rd_valid & exp_rdy;
    for (int p = 0; p < 2; p++) begin
      if (exp_rv[p]) begin
        e.port = p;
        e.data = model[rd_vreg[p]][rd_elem[p]];
        sb.push_back(e);
      end
    end
    cnt_model = sat_add(cnt_model, $countones(rd_valid & ~exp_rdy));
    @(posedge clk);
    if (wr_valid) begin
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) model[wr_vreg][wr_elem][8*i +: 8] = wr_data[8*i +: 8];
    end
    #1;
    check_eq("rd_rvalid", 32'(rd_rvalid), 32'(exp_rv));
    for (int p = 0; p < 2; p++) begin
      if (exp_rv[p] && sb.size() > 0) begin
        e = sb.pop_front();
        check_eq($sformatf("rd_rdata%0d", e.port), rd_rdata[e.port], e.data);
        last_data[e.port] = e.data;
      end else begin
        check_eq($sformatf("rd_rdata%0d_hold", p), rd_rdata[p], last_data[p]);
      end
    end
    check_eq("conflict_cnt", 32'(conflict_cnt), 32'(cnt_model));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    idle();
    model_clear();
    #1;
    check_eq("rst_rvalid", 32'(rd_rvalid), 32'd0);
    check_eq("rst_rdata0", rd_rdata[0], 32'd0);
    check_eq("rst_rdata1", rd_rdata[1], 32'd0);
    check_eq("rst_conflict", 32'(conflict_cnt), 32'd0);
    check_eq("wr_ready", 32'(wr_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    // Storage comes out of reset cleared.
    idle(); drive_rd(0, 0, 3); step(2'b01);

    // Full write, then a read the very next cycle.
    idle(); drive_wr(3, 5, 32'hDEADBEEF, 4'hF); step(2'b00);
    idle(); drive_rd(0, 3, 5); step(2'b01);

    // Byte-enable merge, then a write with no enables.
    idle(); drive_wr(4, 1, 32'hAABBCCDD, 4'hF); step(2'b00);
    idle(); drive_wr(4, 1, 32'h11223344, 4'h5); step(2'b00);
    idle(); drive_rd(0, 4, 1); step(2'b01);
    idle(); drive_wr(4, 1, 32'hFFFFFFFF, 4'h0); step(2'b00);
    idle(); drive_rd(1, 4, 1); step(2'b10);

    // Two different rows in bank 0: alternating grants 0,1,0.
    idle(); drive_wr(1, 0, 32'h0000_0100, 4'hF); step(2'b00);
    idle(); drive_wr(1, 4, 32'h0000_0104, 4'hF); step(2'b00);
    idle(); drive_rd(0, 1, 0); drive_rd(1, 1, 4); step(2'b01);
    step(2'b10);
    step(2'b01);
    check_eq("conflict_after_rr", 32'(conflict_cnt), 32'd3);

    // Same row on both ports: one shared access, both granted.
    idle(); drive_wr(2, 7, 32'h0000_2727, 4'hF); step(2'b00);
    idle(); drive_rd(0, 2, 7); drive_rd(1, 2, 7); step(2'b11);

    // A write blocks a read of its bank. The read is dropped, then retried.
    idle(); drive_wr(5, 2, 32'h0000_55AA, 4'hF); drive_rd(0, 5, 2); step(2'b00);
    idle(); step(2'b00);
    idle(); drive_rd(0, 5, 2); step(2'b01);

    // A write to another bank does not block the reads.
    idle(); drive_wr(6, 1, 32'h0000_6161, 4'hF); drive_rd(0, 5, 2); drive_rd(1, 1, 4);
    step(2'b11);
    idle(); drive_rd(1, 6, 1); step(2'b10);

    // Sustained stalls on both ports drive the counter into saturation.
    idle(); drive_wr(0, 0, 32'h0, 4'h0); drive_rd(0, 1, 0); drive_rd(1, 1, 4);
    repeat (1000) begin
      @(posedge clk);
      cnt_model = sat_add(cnt_model, 2);
    end
    #1;
    check_eq("conflict_mid", 32'(conflict_cnt), 32'(cnt_model));
    repeat (31772) begin
      @(posedge clk);
      cnt_model = sat_add(cnt_model, 2);
    end
    #1;
    check_eq("conflict_sat", 32'(conflict_cnt), 32'(cnt_model));

    // Reset while a response is on the outputs clears it at once.
    idle(); drive_rd(0, 2, 7); step(2'b01);
    idle();
    #2;
    nrst = 1'b0;
    #1;
    check_eq("async_rvalid", 32'(rd_rvalid), 32'd0);
    check_eq("async_rdata0", rd_rdata[0], 32'd0);
    check_eq("async_rdata1", rd_rdata[1], 32'd0);
    check_eq("async_conflict", 32'(conflict_cnt), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    idle(); step(2'b00);
    step(2'b00);
    drive_rd(0, 3, 5); step(2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vrf_banked.md
VRF_BANKED -- requirements
Module: vrf_banked

Interface
REQ-001 SHALL have parameter NumVRs, default 32, number of vector registers (power of 2).
REQ-002 SHALL have parameter ElemsPerVR, default 32, elements per vector register (power of 2, multiple of NumBanks).
REQ-003 SHALL have parameter NumBanks, default 4, number of single-ported element banks (power of 2, >=2).
REQ-004 SHALL have parameter DataWidth, default 32, element width in bits (multiple of 8).
REQ-005 SHALL have parameter NumRdPorts, default 2, number of independent read ports (>=1).
REQ-006 SHALL have clk  input  1  clock; all state is updated on its rising edge.
REQ-007 SHALL have nrst  input  1  reset; asynchronous, active-low.
REQ-008 SHALL have rd_valid  input  NumRdPorts  per-port read request.
REQ-009 SHALL have rd_vreg  input  NumRdPorts x log2(NumVRs)  register index per port.
REQ-010 SHALL have rd_elem  input  NumRdPorts x log2(ElemsPerVR)  element index per port.
REQ-011 SHALL have rd_ready  output  NumRdPorts  per-port grant (combinational).
REQ-012 SHALL have rd_rvalid  output  NumRdPorts  read data valid.
REQ-013 SHALL have rd_rdata  output  NumRdPorts x DataWidth  read data.
REQ-014 SHALL have wr_valid  input  1; wr_vreg  input  log2(NumVRs); wr_elem  input  log2(ElemsPerVR); wr_data  input  DataWidth; wr_be  input  DataWidth/8 byte enables.
REQ-015 SHALL have wr_ready  output  1  write grant (always 1).
REQ-016 SHALL have conflict_cnt  output  16  count of stalled read-port cycles.

Function
REQ-017 Bank SHALL be rd_elem/wr_elem modulo NumBanks; row SHALL be {vreg, elem / NumBanks}.
REQ-018 Each bank SHALL perform at most one row access per cycle.
REQ-019 A write SHALL have priority over all reads to the same bank; a read port targeting that bank SHALL see rd_ready=0.
REQ-020 Among read ports targeting the same bank with different rows, exactly one SHALL be granted, chosen by a per-bank round-robin pointer starting at port 0.
REQ-021 On a grant, that bank's pointer SHALL advance to the port after the winner (wrapping at NumRdPorts); otherwise it SHALL hold.
REQ-022 Read ports targeting the same bank and identical row SHALL all be granted in the same cycle (broadcast), consuming one bank access; the pointer SHALL advance past the lowest-index granted port at or after the pointer.
REQ-023 Accepted read (rd_valid & rd_ready) SHALL produce rd_rvalid=1 with rd_rdata exactly 1 cycle later; rd_rvalid SHALL be 0 in all other cycles.
REQ-024 rd_rdata SHALL hold its last value when rd_rvalid=0.
REQ-025 Write SHALL update only bytes with wr_be bit set; wr_be=0 SHALL leave the element unchanged.
REQ-026 A read accepted in the cycle after a write to the same element SHALL return the written data.
REQ-027 conflict_cnt SHALL increment by the number of ports with rd_valid=1 and rd_ready=0 in the cycle, saturating at 0xFFFF.
REQ-028 Deasserting rd_valid before a grant SHALL be permitted and SHALL leave no pending state.

Reset
REQ-029 On nrst low, all elements SHALL be 0, rd_rvalid=0, rd_rdata=0, round-robin pointers=0, conflict_cnt=0, immediately and independent of clk.
REQ-030 Reset asserted while a read is in flight SHALL cancel it; no rd_rvalid SHALL appear after release.

Verification
REQ-031 Write vreg3 elem5 data 0xDEADBEEF be 0xF, then port0 reads it -> rd_ready0=1, rd_rvalid0=1 next cycle, rd_rdata0=0xDEADBEEF.
REQ-032 Write 0x11223344 be 0x5 over element holding 0xAABBCCDD -> readback 0xAA22CC44.
REQ-033 Ports 0,1 read elem 0 and elem 4 of vreg 1 (bank 0) for 3 cycles -> grants 0,1,0; conflict_cnt=3.
REQ-034 Ports 0,1 read identical vreg2 elem7 -> both granted same cycle, equal data, conflict_cnt unchanged.
REQ-035 Write to bank 2 and port0 read of bank 2 same cycle -> rd_ready0=0; read granted next cycle returns new data.
REQ-036 Assert nrst mid-read and during 0xFFFF+5 stalls -> outputs zero immediately; conflict_cnt saturates at 0xFFFF before reset.
